mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage; owns the HI/LO architectural registers.
- Its `busy` output is the responder side of the hazard-stall handshake.
- The stall controller holds any D-stage HI/LO-touching instruction while `busy` is high, or while `start` is high this cycle.
- Executes MULT/MULTU/DIV/DIVU over a fixed latency; MTHI/MTLO/MFHI/MFLO complete in one cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MFHI 7=MFLO
- wr_en  input  1  E-stage instruction is MTHI/MTLO (qualifies op 4/5)
- rs_data  input  32  operand A (forwarded rs value)
- rt_data  input  32  operand B (forwarded rt value)
- busy  output  1  operation in flight
- hi  output  32  current HI register
- lo  output  32  current LO register
- md_out  output  32  combinational read: hi when op=6, lo when op=7, else 0

Behaviour:
- Reset (async): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result regs=0. Reset mid-operation aborts it; HI/LO stay 0.
- States: IDLE, RUN.
- IDLE, start=1 at edge T:
  - Operands and op are latched.
  - Result is computed into pending regs.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state goes to RUN.
  - busy=1 from T+1.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 1 → 0, pending regs are written into hi/lo and state returns to IDLE.
  - busy is high for exactly N cycles; new hi/lo and busy=0 appear together in the same cycle.
- start is ignored while in RUN; state and counter are unaffected. The stall controller prevents this case; the bench checks robustness.
- MULT: {hi,lo} = signed 32x32 → 64-bit product.
- MULTU: {hi,lo} = unsigned 32x32 → 64-bit product.
- DIV (signed, truncating toward zero):
  - lo = quotient, hi = remainder; remainder sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU (unsigned): lo = quotient, hi = remainder.
- Divide by zero (rt_data=0): the busy sequence runs normally; hi/lo are left unchanged at completion.
- MTHI/MTLO (wr_en=1, op=4/5, start=0):
  - In IDLE: hi or lo is written with rs_data at the edge; visible next cycle.
  - In RUN: ignored.
  - wr_en=1 with start=1: start wins, write dropped.
- MFHI/MFLO: md_out is purely combinational from the current registers. During RUN it returns the old values; the stall controller prevents this use.
- busy is registered; no combinational path from start to busy.
- hi/lo change only on reset, at completion of a multiply/divide, or on an MTHI/MTLO write.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA with busy=0 in the same cycle.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 after MTHI 0x1234 and MTLO 0x5678 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- Start MULT 6×7, assert start=1 with DIV at busy cycle 2, and pulse MTLO 0xAAAA at busy cycle 3 → both ignored; lo=42, hi=0 at completion; busy total is 5 cycles.
- Start DIV 100/3, assert reset asynchronously mid-cycle at busy cycle 4 → busy, hi, lo drop to 0 immediately without waiting for a clock edge; a subsequent MTHI 0x1 in IDLE → hi=0x1 next cycle, md_out=0x1 with op=6.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Results are computed on start and committed to HI/LO after a fixed busy window.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        wr_en,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;
  localparam logic [2:0] OP_MFLO = 3'd7;

  state_t      state, stateNext;
  logic [3:0]  count, countNext;
  logic        loadPend, commit;
  logic [31:0] pendHi, pendLo;
  logic        pendWrite;

  // Operation decode: ops 2/3 divide, even ops are signed.
  logic isDiv, isSigned;
  assign isDiv    = op[1];
  assign isSigned = ~op[0];

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are correct for both signed and unsigned operands.
  logic [63:0] extA, extB, product;
  assign extA    = {{32{isSigned & rs_data[31]}}, rs_data};
  assign extB    = {{32{isSigned & rt_data[31]}}, rt_data};
  assign product = extA * extB;

  // Divide on magnitudes, then fix signs; avoids the signed-overflow corner.
  logic [31:0] absA, absB, uQuot, uRem, quot, rem;
  logic        divByZero;
  assign divByZero = (rt_data == 32'd0);
  assign absA  = (isSigned && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign absB  = (isSigned && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
  assign uQuot = divByZero ? 32'd0 : absA / absB;
  assign uRem  = divByZero ? 32'd0 : absA % absB;
  assign quot  = (isSigned && (rs_data[31] ^ rt_data[31])) ? (32'd0 - uQuot) : uQuot;
  assign rem   = (isSigned && rs_data[31]) ? (32'd0 - uRem) : uRem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    stateNext = state;
    countNext = count;
    loadPend  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          countNext = isDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          loadPend  = 1'b1;
        end
      end
      RUN: begin
        countNext = count - 4'd1;
        if (count == 4'd1) begin
          stateNext = IDLE;
          commit    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendHi    <= 32'd0;
      pendLo    <= 32'd0;
      pendWrite <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else if (loadPend) begin
      pendHi    <= isDiv ? rem  : product[63:32];
      pendLo    <= isDiv ? quot : product[31:0];
      pendWrite <= ~(isDiv && divByZero);
    end else if (commit) begin
      if (pendWrite) begin
        hi <= pendHi;
        lo <= pendLo;
      end
    end else if (state == IDLE && wr_en && !start) begin
      if (op == OP_MTHI) hi <= rs_data;
      if (op == OP_MTLO) lo <= rs_data;
    end
  end

  assign busy   = (state == RUN);
  assign md_out = (op == OP_MFHI) ? hi :
                  (op == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares whenever busy falls.
module tb_mdu_unit;

  typedef struct {
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          cycles;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset, start, wr_en;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int errors = 0;
  int checks = 0;
  expect_t scoreboard[$];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .wr_en(wr_en),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo),
    .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, compare on each busy falling edge.
  initial begin
    logic    prevBusy;
    int      busyCnt;
    expect_t e;
    prevBusy = 1'b0;
    busyCnt  = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      if (prevBusy && busy !== 1'b1) begin
        if (reset === 1'b1) begin
          if (scoreboard.size() > 0) void'(scoreboard.pop_front());
        end else if (scoreboard.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = scoreboard.pop_front();
          check("hi", hi, e.expHi);
          check("lo", lo, e.expLo);
          check("busy_cycles", 32'(busyCnt), 32'(e.cycles));
        end
        busyCnt = 0;
      end
      prevBusy = (busy === 1'b1);
    end
  end

  // All drive tasks are entered and left at posedge+1.
  task automatic startOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eHi, input logic [31:0] eLo, input int cyc);
    expect_t e;
    e.expHi = eHi; e.expLo = eLo; e.cycles = cyc;
    scoreboard.push_back(e);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic mtWrite(input logic [2:0] o, input logic [31:0] v);
    wr_en = 1'b1; op = o; rs_data = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy === 1'b1) check("wait_idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; op = 3'd6;
    rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_md_out", md_out, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    startOp(3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    waitIdle();
    op = 3'd6; #1;
    check("mfhi_after_mult", md_out, 32'hFFFFFFFF);
    op = 3'd7; #1;
    check("mflo_after_mult", md_out, 32'hFFFFFFFA);
    op = 3'd0; #1;
    check("md_out_other_op", md_out, 32'd0);
    @(posedge clk); #1;

    startOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    waitIdle();
    startOp(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    waitIdle();
    startOp(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    waitIdle();
    startOp(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    waitIdle();

    mtWrite(3'd4, 32'h1234);
    mtWrite(3'd5, 32'h5678);
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    startOp(3'd3, 32'd100, 32'd0, 32'h1234, 32'h5678, 10);
    waitIdle();

    // Start and MTLO during RUN must both be ignored.
    startOp(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);
    start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    mtWrite(3'd5, 32'hAAAA);
    check("lo_during_run", lo, 32'h5678);
    waitIdle();

    // Asynchronous reset at busy cycle 4 of a divide.
    startOp(3'd2, 32'd100, 32'd3, 32'd1, 32'd33, 10);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    mtWrite(3'd4, 32'h1);
    check("mthi_after_reset", hi, 32'h1);
    op = 3'd6; #1;
    check("mfhi_after_reset", md_out, 32'h1);
    op = 3'd7; #1;
    check("mflo_after_reset", md_out, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
